// File: rtl/pwled_pkg.sv
// Shared definitions for the password LED controller: FSM state encoding
// and the default values of the top-level parameters.
package pwled_pkg;

  localparam int DEFAULT_MAX_DIGITS   = 6;
  localparam int DEFAULT_BLINK_DIV    = 25_000_000;
  localparam int DEFAULT_BLINK_HALVES = 6;

  typedef enum logic [1:0] {
    ENTRY     = 2'd0,
    SHOW_OK   = 2'd1,
    SHOW_FAIL = 2'd2
  } state_t;

endpackage

// File: rtl/password_led_controller_blink_timer.sv
// Result-display timer: after start it counts BLINK_HALVES half-periods of
// BLINK_DIV cycles each, exposing the half-period index and a final-cycle done.
module blink_timer #(
  parameter  int BLINK_DIV    = 4,
  parameter  int BLINK_HALVES = 6,
  localparam int DIV_W        = $clog2(BLINK_DIV + 1),
  localparam int HALF_W       = $clog2(BLINK_HALVES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              tick,
  output logic [HALF_W-1:0] half_idx,
  output logic              done
);

  logic             active;
  logic [DIV_W-1:0] div_cnt;

  assign tick = active && (div_cnt == DIV_W'(BLINK_DIV - 1));
  assign done = tick && (half_idx == HALF_W'(BLINK_HALVES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      half_idx <= '0;
    end else if (start) begin
      active   <= 1'b1;
      div_cnt  <= '0;
      half_idx <= '0;
    end else if (done) begin
      active   <= 1'b0;
      div_cnt  <= '0;
      half_idx <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      half_idx <= half_idx + 1'b1;
    end else if (active) begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/password_led_controller.sv
// Password entry LED controller: thermometer display of entered digits and a
// timed OK/FAIL result display. Define PASSWORD_LED_BLINK_EN for blinking patterns.
module password_led_controller
  import pwled_pkg::*;
#(
  parameter  int MAX_DIGITS   = DEFAULT_MAX_DIGITS,
  parameter  int BLINK_DIV    = DEFAULT_BLINK_DIV,
  parameter  int BLINK_HALVES = DEFAULT_BLINK_HALVES,
  localparam int CNT_W        = $clog2(MAX_DIGITS + 1),
  localparam int HALF_W       = $clog2(BLINK_HALVES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  digit_valid,
  input  logic                  backspace,
  input  logic                  clear,
  input  logic                  result_valid,
  input  logic                  result_ok,
  output logic [MAX_DIGITS-1:0] led,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  busy
);

  // Fail pattern on even half-periods: bit 0 set, alternating upward.
  localparam logic [MAX_DIGITS-1:0] FAIL_EVEN = MAX_DIGITS'(32'h5555_5555);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                timer_start;
  logic                timer_tick;
  logic                timer_done;
  logic [HALF_W-1:0]   half_idx;
  logic                odd_half;
  logic                unused_timer;

  blink_timer #(
    .BLINK_DIV    (BLINK_DIV),
    .BLINK_HALVES (BLINK_HALVES)
  ) u_blink_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (timer_start),
    .tick     (timer_tick),
    .half_idx (half_idx),
    .done     (timer_done)
  );

  assign unused_timer = ^{timer_tick, half_idx};

  assign count = count_q;
  assign full  = (count_q == CNT_W'(MAX_DIGITS));
  assign busy  = (state_q != ENTRY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTRY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    timer_start = 1'b0;
    case (state_q)
      ENTRY: begin
        // A finished check wins over any simultaneous edit of the entry.
        if (result_valid) begin
          state_d     = result_ok ? SHOW_OK : SHOW_FAIL;
          timer_start = 1'b1;
        end else if (clear) begin
          count_d = '0;
        end else if (backspace) begin
          if (count_q != '0) count_d = count_q - 1'b1;
        end else if (digit_valid) begin
          if (!full) count_d = count_q + 1'b1;
        end
      end
      SHOW_OK, SHOW_FAIL: begin
        if (timer_done) begin
          state_d = ENTRY;
          count_d = '0;
        end
      end
      default: begin
        state_d = ENTRY;
        count_d = '0;
      end
    endcase
  end

`ifdef PASSWORD_LED_BLINK_EN
  assign odd_half = half_idx[0];
`else
  assign odd_half = 1'b0;
`endif

  always_comb begin
    led = '0;
    case (state_q)
      ENTRY: begin
        for (int i = 0; i < MAX_DIGITS; i++) begin
          led[i] = (int'(count_q) > i);
        end
      end
      SHOW_OK:   led = odd_half ? '0 : '1;
      SHOW_FAIL: led = odd_half ? ~FAIL_EVEN : FAIL_EVEN;
      default:   led = '0;
    endcase
  end

endmodule

// File: tb/tb_password_led_controller.sv
// Directed bench for password_led_controller with MAX_DIGITS=6, BLINK_DIV=4,
// BLINK_HALVES=6; expected SHOW patterns follow PASSWORD_LED_BLINK_EN.
module tb_password_led_controller;

  localparam int MD = 6;
  localparam int BD = 4;
  localparam int BH = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        digit_valid, backspace, clear, result_valid, result_ok;
  logic [5:0]  led;
  logic [2:0]  count;
  logic        full, busy;

  int n_checks = 0;
  int n_pass   = 0;

  password_led_controller #(
    .MAX_DIGITS   (MD),
    .BLINK_DIV    (BD),
    .BLINK_HALVES (BH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .digit_valid  (digit_valid),
    .backspace    (backspace),
    .clear        (clear),
    .result_valid (result_valid),
    .result_ok    (result_ok),
    .led          (led),
    .count        (count),
    .full         (full),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_digit();
    digit_valid = 1'b1; step(); digit_valid = 1'b0;
  endtask

  task automatic pulse_backspace();
    backspace = 1'b1; step(); backspace = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  function automatic logic [5:0] ok_pat(input int h);
`ifdef PASSWORD_LED_BLINK_EN
    return (h % 2 == 1) ? 6'b000000 : 6'b111111;
`else
    return (h >= 0) ? 6'b111111 : 6'b000000;
`endif
  endfunction

  function automatic logic [5:0] fail_pat(input int h);
`ifdef PASSWORD_LED_BLINK_EN
    return (h % 2 == 1) ? 6'b101010 : 6'b010101;
`else
    return (h >= 0) ? 6'b010101 : 6'b101010;
`endif
  endfunction

  logic [5:0] therm [7] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F, 6'h3F};
  logic [2:0] cnt_exp [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd6};

  initial begin
    rst_n = 1'b0;
    digit_valid = 1'b0; backspace = 1'b0; clear = 1'b0;
    result_valid = 1'b0; result_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", count, 0);
    check("reset_led",   led,   0);
    check("reset_full",  full,  0);
    check("reset_busy",  busy,  0);
    rst_n = 1'b1;
    step();

    // Seven digits: count saturates at 6.
    for (int i = 0; i < 7; i++) begin
      pulse_digit();
      check($sformatf("digit%0d_count", i), count, cnt_exp[i]);
      check($sformatf("digit%0d_led", i),   led,   therm[i]);
    end
    check("full_at_6", full, 1);
    pulse_backspace();
    check("bs_from_full_count", count, 5);
    check("bs_from_full_full",  full,  0);
    pulse_clear();
    check("clear_count", count, 0);
    check("clear_led",   led,   0);

    // Backspace beats digit_valid.
    repeat (3) pulse_digit();
    backspace = 1'b1; digit_valid = 1'b1;
    step();
    backspace = 1'b0; digit_valid = 1'b0;
    check("bs_vs_digit_count", count, 2);
    check("bs_vs_digit_led",   led,   6'b000011);

    // Clear beats both.
    clear = 1'b1; backspace = 1'b1; digit_valid = 1'b1;
    step();
    clear = 1'b0; backspace = 1'b0; digit_valid = 1'b0;
    check("clear_prio_count", count, 0);
    pulse_backspace();
    check("bs_at_zero_count", count, 0);
    check("bs_at_zero_led",   led,   0);

    // OK display from count 4; result_valid overrides a simultaneous digit.
    repeat (4) pulse_digit();
    result_valid = 1'b1; result_ok = 1'b1; digit_valid = 1'b1;
    step();
    result_valid = 1'b0; result_ok = 1'b0; digit_valid = 1'b0;
    for (int k = 0; k < 24; k++) begin
      check($sformatf("ok_c%0d_busy", k),  busy,  1);
      check($sformatf("ok_c%0d_led", k),   led,   ok_pat(k / 4));
      check($sformatf("ok_c%0d_count", k), count, 4);
      if (k == 5) begin
        result_valid = 1'b1; result_ok = 1'b0; digit_valid = 1'b1;
      end
      step();
      result_valid = 1'b0; digit_valid = 1'b0;
    end
    check("ok_end_busy",  busy,  0);
    check("ok_end_count", count, 0);
    check("ok_end_led",   led,   0);

    // FAIL display from count 2 with digit pulses sprinkled in.
    repeat (2) pulse_digit();
    result_valid = 1'b1; result_ok = 1'b0;
    step();
    result_valid = 1'b0;
    for (int k = 0; k < 24; k++) begin
      check($sformatf("fail_c%0d_busy", k),  busy,  1);
      check($sformatf("fail_c%0d_led", k),   led,   fail_pat(k / 4));
      check($sformatf("fail_c%0d_count", k), count, 2);
      digit_valid = (k % 3 == 0);
      step();
      digit_valid = 1'b0;
    end
    check("fail_end_busy",  busy,  0);
    check("fail_end_count", count, 0);
    check("fail_end_led",   led,   0);

    // Asynchronous reset in the middle of a display.
    pulse_digit();
    result_valid = 1'b1; result_ok = 1'b1;
    step();
    result_valid = 1'b0; result_ok = 1'b0;
    repeat (10) step();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_led",   led,   0);
    check("mid_rst_busy",  busy,  0);
    check("mid_rst_count", count, 0);
    step();
    rst_n = 1'b1;
    pulse_digit();
    check("post_rst_count", count, 1);
    check("post_rst_led",   led,   6'b000001);
    check("post_rst_busy",  busy,  0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/password_led_controller.md
PASSWORD_LED_CONTROLLER -- requirements
Module: password_led_controller

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 6: number of digit LEDs and maximum digit count, legal range 1..15.
REQ-002 SHALL have parameter BLINK_DIV, default 25_000_000: clock cycles per blink half-period, minimum 1.
REQ-003 SHALL have parameter BLINK_HALVES, default 6: number of half-periods in one result display, must be even and at least 2.
REQ-004 SHALL have a single clock; reset is asynchronous and active-low: clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port digit_valid  in  1  one-cycle pulse, one digit entered.
REQ-007 SHALL have port backspace  in  1  one-cycle pulse, remove last digit.
REQ-008 SHALL have port clear  in  1  one-cycle pulse, discard all digits.
REQ-009 SHALL have port result_valid  in  1  one-cycle pulse, password check finished.
REQ-010 SHALL have port result_ok  in  1  check outcome, sampled only with result_valid.
REQ-011 SHALL have port led  out  MAX_DIGITS  LED drive, bit 0 is the first digit.
REQ-012 SHALL have port count  out  $clog2(MAX_DIGITS+1)  digits currently held.
REQ-013 SHALL have port full  out  1  high when count equals MAX_DIGITS.
REQ-014 SHALL have port busy  out  1  high while a result display runs.

Function
REQ-015 SHALL implement the FSM states ENTRY, SHOW_OK and SHOW_FAIL.
REQ-016 In ENTRY, the input priority SHALL be clear > backspace > digit_valid; exactly one action is taken per cycle.
REQ-017 In ENTRY, clear SHALL set count to 0 at the sampling edge.
REQ-018 In ENTRY, backspace SHALL decrement count; backspace at count 0 is ignored.
REQ-019 In ENTRY, digit_valid SHALL increment count; digit_valid at full is ignored, so count saturates at MAX_DIGITS.
REQ-020 In ENTRY, led[i] SHALL be 1 exactly when count > i (thermometer code); led is combinational from registered count and state, with zero added latency after the count update.
REQ-021 In ENTRY, result_valid SHALL move the FSM to SHOW_OK if result_ok=1, otherwise to SHOW_FAIL, at the sampling edge, regardless of count, and SHALL override any simultaneous digit, backspace or clear.
REQ-022 In the SHOW states, busy SHALL be 1 and all inputs SHALL be ignored, including result_valid.
REQ-023 Each SHOW state SHALL last exactly BLINK_DIV*BLINK_HALVES cycles; the half-period index h starts at 0.
REQ-024 SHOW_OK pattern: led is all ones when h is even and all zeros when h is odd.
REQ-025 SHOW_FAIL pattern: led is 0101..b (bit 0 set) when h is even and 1010..b when h is odd.
REQ-026 On the final cycle of a SHOW state, the FSM SHALL return to ENTRY with count=0 and busy=0 at the next edge.
REQ-027 full SHALL be derived combinationally from count.

Reset
REQ-028 While rst_n=0, the block SHALL hold state ENTRY, count=0, led=0, full=0, busy=0, and the blink timer and h at 0.
REQ-029 Reset asserted mid-display SHALL abort the display immediately with no residual pattern.

Configuration
REQ-030 The macro PASSWORD_LED_BLINK_EN SHALL select the result display mode.
REQ-031 With PASSWORD_LED_BLINK_EN defined, the SHOW patterns SHALL alternate as in REQ-024 and REQ-025.
REQ-032 With PASSWORD_LED_BLINK_EN undefined, SHOW_OK SHALL hold all ones and SHOW_FAIL SHALL hold 0101..b steadily, for the same duration; the timer and busy behaviour are unchanged.

Structure
REQ-033 A shared package pwled_pkg SHALL hold the FSM state encoding (ENTRY=2'd0, SHOW_OK=2'd1, SHOW_FAIL=2'd2) and the parameter default constants.
REQ-034 One sub-module, blink_timer, SHALL generate the half-period tick and the h index, with a start input and a done output.

Verification
REQ-035 MAX_DIGITS=6, BLINK_DIV=4: seven digit pulses -> count steps 1..6 then holds at 6, led=6'b111111, full=1 after the sixth pulse.
REQ-036 Count=3, assert backspace and digit_valid together -> count=2, led=6'b000011; backspace at count 0 -> count stays 0.
REQ-037 Count=4, result_valid with result_ok=1 -> busy=1, led all ones for 4 cycles, then all zeros for 4 cycles, repeating; after 24 cycles count=0, busy=0, led=0.
REQ-038 result_valid with result_ok=0 -> led alternates 6'b010101 and 6'b101010 every 4 cycles; digit pulses during the display leave count unaffected.
REQ-039 rst_n pulled low at cycle 10 of a display -> led=0, busy=0, count=0 asynchronously; after release, one digit pulse gives count=1.
REQ-040 Build without PASSWORD_LED_BLINK_EN, fail result -> led holds 6'b010101 for all 24 cycles, then returns to ENTRY.
